dsi_pattern_gen: RTL and testbench



---
 rtl/dsi_pattern_gen_pkg.sv | 51 +++++
 rtl/dsi_pattern_pixel.sv | 42 ++++
 rtl/dsi_pattern_gen.sv | 205 ++++++++++++++++++++
 tb/tb_dsi_pattern_gen.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dsi_pattern_gen_pkg.sv
// Shared definitions for the DSI test-pattern generator: register map,
// pattern mode and state encodings, colour constants and the bar palette.
package dsi_pattern_gen_pkg;

  localparam logic [3:0] REG_PG_CTL    = 4'h0;
  localparam logic [3:0] REG_PG_XSIZE  = 4'h1;
  localparam logic [3:0] REG_PG_YSIZE  = 4'h2;
  localparam logic [3:0] REG_PG_COLOR  = 4'h3;
  localparam logic [3:0] REG_PG_STATUS = 4'h4;

  typedef enum logic [1:0] {
    PG_MODE_COLORBAR = 2'd0,
    PG_MODE_CHECKER  = 2'd1,
    PG_MODE_GRADIENT = 2'd2,
    PG_MODE_SOLID    = 2'd3
  } pg_mode_e;

  typedef enum logic [1:0] {
    PG_ST_IDLE  = 2'd0,
    PG_ST_WAIT  = 2'd1,
    PG_ST_VSYNC = 2'd2,
    PG_ST_IMAGE = 2'd3
  } pg_state_e;

  localparam logic [23:0] PG_BLACK   = 24'h000000;
  localparam logic [23:0] PG_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] PG_RED     = 24'hFF0000;
  localparam logic [23:0] PG_GREEN   = 24'h00FF00;
  localparam logic [23:0] PG_BLUE    = 24'h0000FF;
  localparam logic [23:0] PG_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] PG_CYAN    = 24'h00FFFF;
  localparam logic [23:0] PG_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] PG_GREY    = 24'h808080;

  // Eight-entry colour-bar palette, indexed by the bar number.
  function automatic logic [23:0] pg_bar_color(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = PG_RED;
      3'd1:    c = PG_GREEN;
      3'd2:    c = PG_BLUE;
      3'd3:    c = PG_YELLOW;
      3'd4:    c = PG_CYAN;
      3'd5:    c = PG_MAGENTA;
      3'd6:    c = PG_GREY;
      default: c = PG_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/dsi_pattern_pixel.sv
// Combinational colour for one pixel at (x, y) under the frame's shadowed
// configuration. Pixels beyond the last x index pad a partial word in black.
module dsi_pattern_pixel
  import dsi_pattern_gen_pkg::*;
#(
  parameter int g_bar_shift = 6
) (
  input  logic [12:0] x,
  input  logic [11:0] y,
  input  pg_mode_e    mode,
  input  logic        border_en,
  input  logic [23:0] color,
  input  logic [11:0] xsize,
  input  logic [11:0] ysize,
  output logic [23:0] pixel
);

  logic [12:0] xlast_s;
  logic        on_border_s;

  assign xlast_s     = {1'b0, xsize};
  assign on_border_s = (x == 13'd0) || (y == 12'd0) || (x == xlast_s) || (y == ysize);

  // Priority: pad, border, then the selected pattern.
  always_comb begin
    pixel = PG_BLACK;
    if (x > xlast_s) begin
      pixel = PG_BLACK;
    end else if (border_en && on_border_s) begin
      pixel = PG_WHITE;
    end else begin
      case (mode)
        PG_MODE_COLORBAR: pixel = pg_bar_color(x[g_bar_shift+2:g_bar_shift]);
        PG_MODE_CHECKER:  pixel = (x[g_bar_shift] ^ y[g_bar_shift]) ? color : PG_BLACK;
        PG_MODE_GRADIENT: pixel = {x[7:0], x[7:0], x[7:0]};
        PG_MODE_SOLID:    pixel = color;
        default:          pixel = PG_BLACK;
      endcase
    end
  end

endmodule

// File: rtl/dsi_pattern_gen.sv
// Multi-pixel-per-clock test-pattern source for the DSI packer. Host
// configuration is copied into shadow registers at frame start so that
// writes during a frame only take effect on the following frame.
module dsi_pattern_gen
  import dsi_pattern_gen_pkg::*;
#(
  parameter int g_pixels_per_clock = 1,
  parameter int g_bar_shift        = 6
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  logic [3:0]                      host_a_i,
  input  logic [31:0]                     host_d_i,
  output logic [31:0]                     host_d_o,
  input  logic                            host_wr_i,
  output logic                            fifo_empty_o,
  input  logic                            fifo_rd_i,
  output logic [24*g_pixels_per_clock-1:0] fifo_pixels_o,
  output logic                            pix_vsync_o,
  input  logic                            pix_next_frame_i,
  output logic                            test_en_o
);

  localparam int          W   = 24 * g_pixels_per_clock;
  localparam logic [12:0] P13 = 13'(g_pixels_per_clock);

  logic [3:0]  ctl_r;
  logic [11:0] xsize_r;
  logic [11:0] ysize_r;
  logic [23:0] color_r;
  logic [15:0] frame_cnt_r;

  pg_mode_e    sh_mode_r;
  logic        sh_border_r;
  logic [23:0] sh_color_r;
  logic [11:0] sh_xsize_r;
  logic [11:0] sh_ysize_r;

  pg_state_e   state_r;
  pg_state_e   next_state_s;
  logic [12:0] xcnt_r;
  logic [11:0] ycnt_r;
  logic        vsync_r;
  logic [W-1:0] pixels_r;
  logic [31:0] host_d_r;

  logic         ctl_wr_s;
  logic         en_s;
  logic         pop_s;
  logic         line_end_s;
  logic         frame_end_s;
  logic         start_frame_s;
  logic [W-1:0] word_s;
  logic         unused_host_d_s;

  // A CTL write acts on the same edge that stores it, so a disable never
  // lets one more frame-start or pixel through.
  assign ctl_wr_s      = host_wr_i && (host_a_i == REG_PG_CTL);
  assign en_s          = ctl_wr_s ? host_d_i[0] : ctl_r[0];
  assign pop_s         = fifo_rd_i && (state_r == PG_ST_IMAGE);
  assign line_end_s    = (xcnt_r + P13 - 13'd1) >= {1'b0, sh_xsize_r};
  assign frame_end_s   = pop_s && line_end_s && (ycnt_r == sh_ysize_r);
  assign start_frame_s = (state_r == PG_ST_WAIT) && (next_state_s == PG_ST_VSYNC);
  assign unused_host_d_s = ^host_d_i[31:24];

  assign fifo_empty_o  = (state_r != PG_ST_IMAGE);
  assign fifo_pixels_o = pixels_r;
  assign pix_vsync_o   = vsync_r;
  assign host_d_o      = host_d_r;
  assign test_en_o     = ctl_r[0];

  for (genvar k = 0; k < g_pixels_per_clock; k++) begin : g_pix
    logic [12:0] x_s;
    assign x_s = xcnt_r + 13'(k);
    dsi_pattern_pixel #(.g_bar_shift(g_bar_shift)) u_pixel (
      .x         (x_s),
      .y         (ycnt_r),
      .mode      (sh_mode_r),
      .border_en (sh_border_r),
      .color     (sh_color_r),
      .xsize     (sh_xsize_r),
      .ysize     (sh_ysize_r),
      .pixel     (word_s[24*k +: 24])
    );
  end

  // Frame sequencing; a cleared enable overrides every transition.
  always_comb begin
    next_state_s = state_r;
    if (!en_s) begin
      next_state_s = PG_ST_IDLE;
    end else begin
      case (state_r)
        PG_ST_IDLE:  next_state_s = PG_ST_WAIT;
        PG_ST_WAIT:  next_state_s = pix_next_frame_i ? PG_ST_VSYNC : PG_ST_WAIT;
        PG_ST_VSYNC: next_state_s = pix_next_frame_i ? PG_ST_VSYNC : PG_ST_IMAGE;
        PG_ST_IMAGE: next_state_s = frame_end_s ? PG_ST_WAIT : PG_ST_IMAGE;
        default:     next_state_s = PG_ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r <= PG_ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Host-programmable registers; STATUS and unmapped addresses are read-only.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ctl_r   <= 4'd0;
      xsize_r <= 12'd0;
      ysize_r <= 12'd0;
      color_r <= 24'd0;
    end else if (host_wr_i) begin
      case (host_a_i)
        REG_PG_CTL:   ctl_r   <= host_d_i[3:0];
        REG_PG_XSIZE: xsize_r <= host_d_i[11:0];
        REG_PG_YSIZE: ysize_r <= host_d_i[11:0];
        REG_PG_COLOR: color_r <= host_d_i[23:0];
        default:      ;
      endcase
    end
  end

  // Shadow copy of the configuration taken at the vsync handshake.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sh_mode_r   <= PG_MODE_COLORBAR;
      sh_border_r <= 1'b0;
      sh_color_r  <= 24'd0;
      sh_xsize_r  <= 12'd0;
      sh_ysize_r  <= 12'd0;
    end else if (start_frame_s) begin
      sh_mode_r   <= pg_mode_e'(ctl_r[2:1]);
      sh_border_r <= ctl_r[3];
      sh_color_r  <= color_r;
      sh_xsize_r  <= xsize_r;
      sh_ysize_r  <= ysize_r;
    end
  end

  // Raster position of the next word to be popped.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      xcnt_r <= 13'd0;
      ycnt_r <= 12'd0;
    end else if ((state_r == PG_ST_IDLE) || (next_state_s == PG_ST_IDLE) || start_frame_s) begin
      xcnt_r <= 13'd0;
      ycnt_r <= 12'd0;
    end else if (pop_s) begin
      if (line_end_s) begin
        xcnt_r <= 13'd0;
        ycnt_r <= (ycnt_r == sh_ysize_r) ? 12'd0 : ycnt_r + 12'd1;
      end else begin
        xcnt_r <= xcnt_r + P13;
      end
    end
  end

  // Completed-frame counter; survives disable, wraps at 16 bits.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      frame_cnt_r <= 16'd0;
    end else if (frame_end_s && en_s) begin
      frame_cnt_r <= frame_cnt_r + 16'd1;
    end
  end

  // Packer-facing outputs: vsync tracks VSYNC, pixel word loads on a pop.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vsync_r  <= 1'b0;
      pixels_r <= {W{1'b0}};
    end else begin
      vsync_r <= (next_state_s == PG_ST_VSYNC);
      if (!en_s) begin
        pixels_r <= {W{1'b0}};
      end else if (pop_s) begin
        pixels_r <= word_s;
      end
    end
  end

  // Registered host read-back.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      host_d_r <= 32'd0;
    end else begin
      case (host_a_i)
        REG_PG_CTL:    host_d_r <= {28'd0, ctl_r};
        REG_PG_XSIZE:  host_d_r <= {20'd0, xsize_r};
        REG_PG_YSIZE:  host_d_r <= {20'd0, ysize_r};
        REG_PG_COLOR:  host_d_r <= {8'd0, color_r};
        REG_PG_STATUS: host_d_r <= {14'd0, state_r, frame_cnt_r};
        default:       host_d_r <= 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_dsi_pattern_gen.sv
// Bench for dsi_pattern_gen: three instances (1, 2 and 4 pixels per clock)
// share the host bus; each frame is replayed against a raster model with
// random pop spacing and random configurations.
module tb_dsi_pattern_gen;

  localparam logic [3:0] A_CTL = 4'h0;
  localparam logic [3:0] A_XS  = 4'h1;
  localparam logic [3:0] A_YS  = 4'h2;
  localparam logic [3:0] A_COL = 4'h3;
  localparam logic [3:0] A_ST  = 4'h4;
  localparam logic [23:0] BARS [8] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFF00,
                                       24'h00FFFF, 24'hFF00FF, 24'h808080, 24'h000000};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  host_a;
  logic [31:0] host_d;
  logic        host_wr;
  logic        rd [3];
  logic        nf [3];
  logic [95:0] pix [3];
  logic [31:0] hd [3];
  logic        empty [3];
  logic        vsync [3];
  logic        ten [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int P = 1 << g;
    logic [24*P-1:0] pw;
    dsi_pattern_gen #(.g_pixels_per_clock(P), .g_bar_shift(6)) u_dut (
      .clk_i(clk), .rst_n_i(rst_n), .host_a_i(host_a), .host_d_i(host_d),
      .host_d_o(hd[g]), .host_wr_i(host_wr), .fifo_empty_o(empty[g]),
      .fifo_rd_i(rd[g]), .fifo_pixels_o(pw), .pix_vsync_o(vsync[g]),
      .pix_next_frame_i(nf[g]), .test_en_o(ten[g])
    );
    assign pix[g] = 96'(pw);
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cfg_mode, cfg_xs, cfg_ys, sh_mode, sh_xs, sh_ys;
  bit cfg_border, sh_border;
  logic [23:0] cfg_color, sh_color;
  int fcnt [3];
  logic [95:0] last [3];

  task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [3:0] a, input logic [31:0] d);
    host_a = a; host_d = d; host_wr = 1'b1;
    tick();
    host_wr = 1'b0;
  endtask

  task automatic host_read(input logic [3:0] a);
    host_a = a;
    tick();
  endtask

  // Colour of one pixel from the pattern rules and the frame's configuration.
  function automatic logic [23:0] ref_pix(input int x, input int y);
    if (x > sh_xs) return 24'h000000;
    if (sh_border && (x == 0 || y == 0 || x == sh_xs || y == sh_ys)) return 24'hFFFFFF;
    case (sh_mode)
      0:       return BARS[(x / 64) % 8];
      1:       return (((x / 64) + (y / 64)) % 2 == 1) ? sh_color : 24'h000000;
      2:       return 24'((x % 256) * 24'h010101);
      default: return sh_color;
    endcase
  endfunction

  function automatic logic [95:0] ref_word(input int x, input int y, input int p);
    logic [95:0] w;
    w = 96'd0;
    for (int k = 0; k < p; k++) w[24*k +: 24] = ref_pix(x + k, y);
    return w;
  endfunction

  task automatic configure(input int mode, input bit border, input int xs, input int ys,
                           input logic [23:0] col);
    cfg_mode = mode; cfg_border = border; cfg_xs = xs; cfg_ys = ys; cfg_color = col;
    host_write(A_XS, {20'($urandom), 12'(xs)});
    host_write(A_YS, {20'($urandom), 12'(ys)});
    host_write(A_COL, {8'($urandom), col});
    host_write(A_CTL, {28'd0, border, 2'(mode), 1'b1});
    for (int g = 0; g < 3; g++) check_eq("test_en_on", 96'(ten[g]), 96'd1);
  endtask

  // ev_kind: 0 none, 1 COLOR write, 2 disable, 3 async reset -- after pop ev_at.
  task automatic run_frame(input int g, input int ev_at, input int ev_kind, input logic [23:0] ev_d);
    int p, n, k;
    logic [95:0] exp;
    p = 1 << g;
    rd[g] = 1'b1;
    tick();
    rd[g] = 1'b0;
    check_eq("rd_outside_image_hold", pix[g], last[g]);
    check_eq("rd_outside_image_empty", 96'(empty[g]), 96'd1);
    sh_mode = cfg_mode; sh_border = cfg_border; sh_color = cfg_color;
    sh_xs = cfg_xs; sh_ys = cfg_ys;
    nf[g] = 1'b1;
    n = 0;
    do begin tick(); n++; end while (vsync[g] !== 1'b1 && n < 8);
    check_eq("vsync_rise", 96'(vsync[g]), 96'd1);
    nf[g] = 1'b0;
    tick();
    check_eq("vsync_fall", 96'(vsync[g]), 96'd0);
    check_eq("image_not_empty", 96'(empty[g]), 96'd0);
    k = 0;
    for (int y = 0; y <= sh_ys; y++) begin
      for (int x = 0; x <= sh_xs; x += p) begin
        repeat ($urandom_range(0, 2)) tick();
        check_eq("pix_hold", pix[g], last[g]);
        rd[g] = 1'b1;
        tick();
        rd[g] = 1'b0;
        exp = ref_word(x, y, p);
        check_eq($sformatf("pix_p%0d_x%0d_y%0d", p, x, y), pix[g], exp);
        last[g] = exp;
        k++;
        if (k == ev_at && ev_kind == 1) begin
          cfg_color = ev_d;
          host_write(A_COL, {8'd0, ev_d});
        end else if (k == ev_at && ev_kind == 2) begin
          host_write(A_CTL, {28'd0, cfg_border, 2'(cfg_mode), 1'b0});
          for (int j = 0; j < 3; j++) begin
            check_eq("disable_empty", 96'(empty[j]), 96'd1);
            check_eq("disable_pix_zero", pix[j], 96'd0);
            check_eq("disable_test_en", 96'(ten[j]), 96'd0);
            last[j] = 96'd0;
          end
          host_read(A_ST);
          check_eq("disable_status", 96'(hd[g]), 96'(fcnt[g]));
          return;
        end else if (k == ev_at && ev_kind == 3) begin
          #2 rst_n = 1'b0;
          #1;
          for (int j = 0; j < 3; j++) begin
            check_eq("areset_empty", 96'(empty[j]), 96'd1);
            check_eq("areset_vsync", 96'(vsync[j]), 96'd0);
            check_eq("areset_pix", pix[j], 96'd0);
            check_eq("areset_host_d", 96'(hd[j]), 96'd0);
            check_eq("areset_test_en", 96'(ten[j]), 96'd0);
            fcnt[j] = 0; last[j] = 96'd0;
          end
          #3 rst_n = 1'b1;
          host_read(A_ST);
          check_eq("areset_status", 96'(hd[g]), 96'd0);
          return;
        end
      end
    end
    fcnt[g] = (fcnt[g] + 1) % 65536;
    check_eq("frame_end_empty", 96'(empty[g]), 96'd1);
    host_read(A_ST);
    check_eq("frame_end_status", 96'(hd[g]), 96'(32'h0001_0000 + fcnt[g]));
  endtask

  initial begin
    logic [31:0] r;
    rst_n = 1'b0; host_a = 4'd0; host_d = 32'd0; host_wr = 1'b0;
    for (int g = 0; g < 3; g++) begin
      rd[g] = 1'b0; nf[g] = 1'b0; fcnt[g] = 0; last[g] = 96'd0;
    end
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    for (int g = 0; g < 3; g++) begin
      check_eq("reset_empty", 96'(empty[g]), 96'd1);
      check_eq("reset_vsync", 96'(vsync[g]), 96'd0);
      check_eq("reset_pix", pix[g], 96'd0);
      check_eq("reset_host_d", 96'(hd[g]), 96'd0);
      check_eq("reset_test_en", 96'(ten[g]), 96'd0);
    end

    // Register map: masking, read-only STATUS, unmapped addresses.
    r = $urandom;
    host_write(A_XS, r);
    host_read(A_XS);
    check_eq("xsize_readback", 96'(hd[0]), 96'(r[11:0]));
    r = $urandom;
    host_write(A_COL, r);
    host_read(A_COL);
    check_eq("color_readback", 96'(hd[1]), 96'(r[23:0]));
    host_write(A_ST, 32'hFFFF_FFFF);
    host_read(A_ST);
    check_eq("status_write_ignored", 96'(hd[2]), 96'd0);
    host_write(4'h9, 32'hDEAD_BEEF);
    host_read(4'h9);
    check_eq("unmapped_read", 96'(hd[0]), 96'd0);
    host_read(A_CTL);
    check_eq("ctl_still_zero", 96'(hd[0]), 96'd0);

    configure(0, 1'b1, 3, 1, 24'h0);
    for (int g = 0; g < 3; g++) run_frame(g, 0, 0, 24'h0);
    configure(0, 1'b0, 199, 9, 24'(($urandom)));
    for (int g = 0; g < 3; g++) run_frame(g, 0, 0, 24'h0);
    configure(3, 1'b0, 4, 1, 24'h123456);
    for (int g = 0; g < 3; g++) run_frame(g, 0, 0, 24'h0);
    configure(2, 1'b0, 255, 1, 24'h0);
    for (int g = 0; g < 3; g++) run_frame(g, 0, 0, 24'h0);
    configure(1, 1'b0, 130, 70, 24'h5A5A5A);
    run_frame(2, 0, 0, 24'h0);

    // COLOR written mid-frame applies only to the next frame.
    configure(3, 1'b0, 7, 3, 24'hFF0000);
    run_frame(1, 5, 1, 24'h00FF00);
    run_frame(1, 0, 0, 24'h0);

    repeat (20) begin
      configure($urandom_range(0, 3), 1'($urandom), $urandom_range(0, 40),
                $urandom_range(0, 5), 24'($urandom));
      run_frame($urandom_range(0, 2), 0, 0, 24'h0);
    end

    // Disable mid-image, then disable racing a next-frame request.
    configure(0, 1'b1, 20, 3, 24'h0);
    run_frame(2, 7, 2, 24'h0);
    host_write(A_CTL, 32'd1);
    host_a = A_CTL; host_d = 32'd0; host_wr = 1'b1;
    for (int g = 0; g < 3; g++) nf[g] = 1'b1;
    tick();
    host_wr = 1'b0;
    for (int g = 0; g < 3; g++) nf[g] = 1'b0;
    for (int g = 0; g < 3; g++) begin
      check_eq("disable_wins_vsync", 96'(vsync[g]), 96'd0);
      check_eq("disable_wins_empty", 96'(empty[g]), 96'd1);
    end
    host_read(A_ST);
    check_eq("disable_wins_status", 96'(hd[0]), 96'(fcnt[0]));
    configure(0, 1'b1, 20, 3, 24'h0);
    run_frame(2, 0, 0, 24'h0);

    // Asynchronous reset in the middle of a frame, then recovery.
    configure(2, 1'b0, 30, 2, 24'h0);
    run_frame(1, 4, 3, 24'h0);
    configure(3, 1'b1, 9, 2, 24'h00AA55);
    run_frame(0, 0, 0, 24'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
